// File: rtl/waterfall_sequencer_if.sv
// Shift-register control bundle between waterfall_sequencer (master) and a 74194-style register (slave).
interface waterfall_sequencer_if;
  logic       S1;
  logic       S0;
  logic [7:0] D;
  logic       DSR;
  logic       DSL;

  modport master (output S1, output S0, output D, output DSR, output DSL);
  modport slave  (input  S1, input  S0, input  D, input  DSR, input  DSL);
endinterface

// File: rtl/waterfall_sequencer.sv
// waterfall_sequencer: drives a 74194-style shift register with LED waterfall patterns.
// Define WATERFALL_STEP_CNT_EN to add the step_cnt output.
module waterfall_sequencer #(
  parameter int unsigned TICK_DIV = 25,
  parameter int unsigned CNT_W    = 24
) (
  input  logic                  CP,
  input  logic                  clr_n,
  input  logic                  en,
  input  logic [1:0]            pat,
  waterfall_sequencer_if.master sr,
  output logic                  step,
  output logic [7:0]            shadow
`ifdef WATERFALL_STEP_CNT_EN
  ,
  output logic [15:0]           step_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;
  typedef enum logic [1:0] {
    PAT_CHASE_R = 2'b00,
    PAT_CHASE_L = 2'b01,
    PAT_PING    = 2'b10,
    PAT_FILL    = 2'b11
  } pat_t;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  function automatic logic [7:0] f_seed(input logic [1:0] p);
    case (p)
      2'b01:   f_seed = 8'h01;
      2'b11:   f_seed = 8'h00;
      default: f_seed = 8'h80;
    endcase
  endfunction

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_mode, w_mode_nxt;
  logic [7:0]       r_d, w_d_nxt;
  logic             r_dsr, w_dsr_nxt;
  logic             r_dsl, w_dsl_nxt;
  logic             r_step, w_step_nxt;
  logic [7:0]       r_shadow, w_shadow_nxt;
  pat_t             r_pat_q, w_pat_nxt;
  logic             r_dir_left, w_dir_left_nxt;
  logic             r_fill, w_fill_nxt;
  logic [2:0]       r_fcnt, w_fcnt_nxt;
  logic             w_load;
  logic [7:0]       w_shr0, w_shl0;

  assign w_shr0 = {1'b0, r_shadow[7:1]};
  assign w_shl0 = {r_shadow[6:0], 1'b0};

  always_ff @(posedge CP or negedge clr_n) begin
    if (!clr_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_mode     <= MODE_HOLD;
      r_d        <= '0;
      r_dsr      <= 1'b0;
      r_dsl      <= 1'b0;
      r_step     <= 1'b0;
      r_shadow   <= '0;
      r_pat_q    <= PAT_CHASE_R;
      r_dir_left <= 1'b0;
      r_fill     <= 1'b0;
      r_fcnt     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_mode     <= w_mode_nxt;
      r_d        <= w_d_nxt;
      r_dsr      <= w_dsr_nxt;
      r_dsl      <= w_dsl_nxt;
      r_step     <= w_step_nxt;
      r_shadow   <= w_shadow_nxt;
      r_pat_q    <= w_pat_nxt;
      r_dir_left <= w_dir_left_nxt;
      r_fill     <= w_fill_nxt;
      r_fcnt     <= w_fcnt_nxt;
    end
  end

  // Outputs are registered, so every value here is what the register sees next cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_mode_nxt     = MODE_HOLD;
    w_d_nxt        = r_d;
    w_dsr_nxt      = 1'b0;
    w_dsl_nxt      = 1'b0;
    w_step_nxt     = 1'b0;
    w_shadow_nxt   = r_shadow;
    w_pat_nxt      = r_pat_q;
    w_dir_left_nxt = r_dir_left;
    w_fill_nxt     = r_fill;
    w_fcnt_nxt     = r_fcnt;
    w_load         = 1'b0;

    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (en) w_load = 1'b1;
      end
      LOAD: begin
        w_cnt_nxt   = CNT_W'(1);
        w_state_nxt = en ? RUN : HOLD;
      end
      RUN: begin
        if (r_cnt == TICK_LAST) begin
          w_cnt_nxt = '0;
          if (pat != r_pat_q) begin
            w_load = 1'b1;
          end else begin
            w_step_nxt  = 1'b1;
            w_state_nxt = en ? RUN : HOLD;
            unique case (r_pat_q)
              PAT_CHASE_R: begin
                w_mode_nxt   = MODE_SHR;
                w_dsr_nxt    = r_shadow[0];
                w_shadow_nxt = {r_shadow[0], r_shadow[7:1]};
              end
              PAT_CHASE_L: begin
                w_mode_nxt   = MODE_SHL;
                w_dsl_nxt    = r_shadow[7];
                w_shadow_nxt = {r_shadow[6:0], r_shadow[7]};
              end
              PAT_PING: begin
                if (!r_dir_left) begin
                  w_mode_nxt   = MODE_SHR;
                  w_shadow_nxt = w_shr0;
                  if (w_shr0 == 8'h01) w_dir_left_nxt = 1'b1;
                end else begin
                  w_mode_nxt   = MODE_SHL;
                  w_shadow_nxt = w_shl0;
                  if (w_shl0 == 8'h80) w_dir_left_nxt = 1'b0;
                end
              end
              PAT_FILL: begin
                w_mode_nxt   = MODE_SHR;
                w_dsr_nxt    = r_fill;
                w_shadow_nxt = {r_fill, r_shadow[7:1]};
                if (r_fcnt == 3'd7) begin
                  w_fill_nxt = ~r_fill;
                  w_fcnt_nxt = '0;
                end else begin
                  w_fcnt_nxt = r_fcnt + 3'd1;
                end
              end
            endcase
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (!en) w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (en) w_state_nxt = RUN;
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_load) begin
      w_state_nxt    = LOAD;
      w_cnt_nxt      = '0;
      w_mode_nxt     = MODE_LOAD;
      w_d_nxt        = f_seed(pat);
      w_shadow_nxt   = f_seed(pat);
      w_pat_nxt      = pat_t'(pat);
      w_dir_left_nxt = 1'b0;
      w_fill_nxt     = 1'b1;
      w_fcnt_nxt     = '0;
    end
  end

`ifdef WATERFALL_STEP_CNT_EN
  logic [15:0] r_step_cnt;

  always_ff @(posedge CP or negedge clr_n) begin
    if (!clr_n)          r_step_cnt <= '0;
    else if (w_load)     r_step_cnt <= '0;
    else if (w_step_nxt) r_step_cnt <= r_step_cnt + 16'd1;
  end

  assign step_cnt = r_step_cnt;
`endif

  assign sr.S1  = r_mode[1];
  assign sr.S0  = r_mode[0];
  assign sr.D   = r_d;
  assign sr.DSR = r_dsr;
  assign sr.DSL = r_dsl;
  assign step   = r_step;
  assign shadow = r_shadow;

endmodule
